// File: rtl/ejecutor_ciclo_pkg.sv
// Shared definitions for the wash-cycle executor: phase encoding (matches the FASE port),
// operating modes and a helper that tells which phases are actively running.
package ejecutor_ciclo_pkg;

  typedef enum logic [2:0] {
    FASE_IDLE     = 3'd0,
    FASE_LLENADO  = 3'd1,
    FASE_LAVADO   = 3'd2,
    FASE_ENJUAGUE = 3'd3,
    FASE_CENTRIF  = 3'd4,
    FASE_SECADO   = 3'd5,
    FASE_FIN      = 3'd6
  } fase_e;

  typedef enum logic [1:0] {
    MODO_NINGUNO = 2'd0,
    MODO_NORMAL  = 2'd1,
    MODO_PESADO  = 2'd2,
    MODO_SEC     = 2'd3
  } modo_e;

  typedef struct packed {
    logic valvula_agua;
    logic motor_lavado;
    logic motor_centrif;
    logic calentador;
  } actuadores_t;

  localparam int NUM_CMD = 3;

  function automatic logic es_fase_activa(fase_e f);
    return (f == FASE_LLENADO) || (f == FASE_LAVADO) || (f == FASE_ENJUAGUE) ||
           (f == FASE_CENTRIF) || (f == FASE_SECADO);
  endfunction

endpackage

// File: rtl/ejecutor_ciclo_if.sv
// Command/status bundle between the payment controller (master) and the cycle executor (slave),
// including the door sensor and the actuator drive lines.
interface ejecutor_ciclo_if;

  logic       SECADO;
  logic       LAVADO;
  logic       LAVADO_PESADO;
  logic       PUERTA_ABIERTA;
  logic       OCUPADO;
  logic       FIN;
  logic       ERROR_CMD;
  logic       PAUSA;
  logic       VALVULA_AGUA;
  logic       MOTOR_LAVADO;
  logic       MOTOR_CENTRIF;
  logic       CALENTADOR;
  logic [2:0] FASE;

  modport master (
    output SECADO, LAVADO, LAVADO_PESADO, PUERTA_ABIERTA,
    input  OCUPADO, FIN, ERROR_CMD, PAUSA, VALVULA_AGUA, MOTOR_LAVADO,
           MOTOR_CENTRIF, CALENTADOR, FASE
  );

  modport slave (
    input  SECADO, LAVADO, LAVADO_PESADO, PUERTA_ABIERTA,
    output OCUPADO, FIN, ERROR_CMD, PAUSA, VALVULA_AGUA, MOTOR_LAVADO,
           MOTOR_CENTRIF, CALENTADOR, FASE
  );

endinterface

// File: rtl/ejecutor_ciclo_temporizador_fase.sv
// Phase down-counter: loads a start value, counts down to zero while enabled and
// holds there, so the owning FSM can leave the phase on the zero cycle.
module temporizador_fase #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             enable,
  output logic             zero
);

  logic [CNT_W-1:0] cuenta;

  always_ff @(posedge clk) begin
    if (reset) begin
      cuenta <= '0;
    end else if (load) begin
      cuenta <= load_val;
    end else if (enable && (cuenta != '0)) begin
      cuenta <= cuenta - CNT_W'(1);
    end
  end

  assign zero = (cuenta == '0);

endmodule

// File: rtl/ejecutor_ciclo.sv
// Wash-cycle executor: turns command rising edges into timed phase sequences and decodes
// the actuator outputs from the current phase, mode and door state.
module ejecutor_ciclo
  import ejecutor_ciclo_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int T_LLENADO    = 8,
  parameter int T_LAVADO     = 16,
  parameter int T_LAVADO_PES = 32,
  parameter int T_ENJUAGUE   = 8,
  parameter int T_CENTRIF    = 8,
  parameter int T_SECADO     = 16
) (
  input  logic             clk,
  input  logic             reset,
  ejecutor_ciclo_if.slave  bus
);

  function automatic bit t_valido(int t);
    return (t >= 1) && (longint'(t) < (longint'(1) << CNT_W));
  endfunction

  if (!(t_valido(T_LLENADO) && t_valido(T_LAVADO) && t_valido(T_LAVADO_PES) &&
        t_valido(T_ENJUAGUE) && t_valido(T_CENTRIF) && t_valido(T_SECADO))) begin : g_t_invalido
    $error("ejecutor_ciclo: every phase length must satisfy 1 <= T < 2**CNT_W");
  end

  // Timer is loaded with T-1 so that the phase, which exits on the zero cycle, lasts exactly T.
  localparam logic [CNT_W-1:0] C_LLENADO    = CNT_W'(T_LLENADO - 1);
  localparam logic [CNT_W-1:0] C_LAVADO     = CNT_W'(T_LAVADO - 1);
  localparam logic [CNT_W-1:0] C_LAVADO_PES = CNT_W'(T_LAVADO_PES - 1);
  localparam logic [CNT_W-1:0] C_ENJUAGUE   = CNT_W'(T_ENJUAGUE - 1);
  localparam logic [CNT_W-1:0] C_CENTRIF    = CNT_W'(T_CENTRIF - 1);
  localparam logic [CNT_W-1:0] C_SECADO     = CNT_W'(T_SECADO - 1);

  fase_e              estado, estado_n;
  modo_e              modo, modo_n;
  logic               error_q, error_n;
  logic [NUM_CMD-1:0] cmd, cmd_q, flancos;
  logic               multi_flanco;
  logic               puerta;
  logic               activa;
  logic               carga;
  logic [CNT_W-1:0]   valor_carga;
  logic               cero;
  logic               avanza;
  actuadores_t        act;

  assign cmd          = {bus.LAVADO_PESADO, bus.LAVADO, bus.SECADO};
  assign flancos      = cmd & ~cmd_q;
  assign multi_flanco = (flancos[0] & flancos[1]) | (flancos[0] & flancos[2]) |
                        (flancos[1] & flancos[2]);
  assign puerta       = bus.PUERTA_ABIERTA;
  assign activa       = es_fase_activa(estado);
  assign avanza       = cero & ~puerta;

  // Edge history resets to 1 so a command level held through reset is not taken as a new request.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q   <= '1;
      estado  <= FASE_IDLE;
      modo    <= MODO_NINGUNO;
      error_q <= 1'b0;
    end else begin
      cmd_q   <= cmd;
      estado  <= estado_n;
      modo    <= modo_n;
      error_q <= error_n;
    end
  end

  temporizador_fase #(.CNT_W(CNT_W)) u_temporizador (
    .clk      (clk),
    .reset    (reset),
    .load     (carga),
    .load_val (valor_carga),
    .enable   (activa & ~puerta),
    .zero     (cero)
  );

  always_comb begin
    estado_n    = estado;
    modo_n      = modo;
    error_n     = 1'b0;
    carga       = 1'b0;
    valor_carga = '0;
    case (estado)
      FASE_IDLE: begin
        if (|flancos) begin
          if (multi_flanco || puerta) begin
            error_n = 1'b1;
          end else if (flancos[2]) begin
            estado_n    = FASE_LLENADO;
            modo_n      = MODO_PESADO;
            carga       = 1'b1;
            valor_carga = C_LLENADO;
          end else if (flancos[1]) begin
            estado_n    = FASE_LLENADO;
            modo_n      = MODO_NORMAL;
            carga       = 1'b1;
            valor_carga = C_LLENADO;
          end else begin
            estado_n    = FASE_SECADO;
            modo_n      = MODO_SEC;
            carga       = 1'b1;
            valor_carga = C_SECADO;
          end
        end
      end
      FASE_LLENADO: begin
        if (avanza) begin
          estado_n    = FASE_LAVADO;
          carga       = 1'b1;
          valor_carga = (modo == MODO_PESADO) ? C_LAVADO_PES : C_LAVADO;
        end
      end
      FASE_LAVADO: begin
        if (avanza) begin
          estado_n    = FASE_ENJUAGUE;
          carga       = 1'b1;
          valor_carga = C_ENJUAGUE;
        end
      end
      FASE_ENJUAGUE: begin
        if (avanza) begin
          estado_n    = FASE_CENTRIF;
          carga       = 1'b1;
          valor_carga = C_CENTRIF;
        end
      end
      FASE_CENTRIF, FASE_SECADO: begin
        if (avanza) begin
          estado_n = FASE_FIN;
        end
      end
      FASE_FIN: begin
        estado_n = FASE_IDLE;
        modo_n   = MODO_NINGUNO;
      end
      default: begin
        estado_n = FASE_IDLE;
        modo_n   = MODO_NINGUNO;
      end
    endcase
  end

  // An open door silences every actuator but leaves phase and busy status untouched.
  always_comb begin
    act = '0;
    if (!puerta) begin
      case (estado)
        FASE_LLENADO:  act.valvula_agua = 1'b1;
        FASE_LAVADO: begin
          act.motor_lavado = 1'b1;
          act.calentador   = (modo == MODO_PESADO);
        end
        FASE_ENJUAGUE: begin
          act.valvula_agua = 1'b1;
          act.motor_lavado = 1'b1;
        end
        FASE_CENTRIF:  act.motor_centrif = 1'b1;
        FASE_SECADO: begin
          act.motor_lavado = 1'b1;
          act.calentador   = 1'b1;
        end
        default:       act = '0;
      endcase
    end
  end

  assign bus.FASE          = estado;
  assign bus.OCUPADO       = activa;
  assign bus.FIN           = (estado == FASE_FIN);
  assign bus.ERROR_CMD     = error_q;
  assign bus.PAUSA         = activa & puerta;
  assign bus.VALVULA_AGUA  = act.valvula_agua;
  assign bus.MOTOR_LAVADO  = act.motor_lavado;
  assign bus.MOTOR_CENTRIF = act.motor_centrif;
  assign bus.CALENTADOR    = act.calentador;

endmodule

// File: tb/tb_ejecutor_ciclo.sv
// Directed bench for ejecutor_ciclo: expected per-cycle output vectors are queued when a
// command is driven and popped/compared on every cycle they are due.
module tb_ejecutor_ciclo;

  logic clk;
  logic reset;

  ejecutor_ciclo_if bus ();

  ejecutor_ciclo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [10:0] v;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          cyc;
  int          vectors;
  int          miscompares;

  logic [10:0] v_idle, v_llen, v_lav, v_lavp, v_enj, v_cen, v_sec, v_fin, v_err, v_pausa;

  // Vector layout: {FASE, OCUPADO, FIN, ERROR_CMD, PAUSA, VALVULA, MOTOR_LAV, MOTOR_CEN, CALENT}.
  function automatic logic [10:0] vec(logic [2:0] f, logic oc, logic fin, logic err, logic pa,
                                      logic va, logic ml, logic mc, logic ca);
    return {f, oc, fin, err, pa, va, ml, mc, ca};
  endfunction

  function automatic logic [10:0] observed();
    return {bus.FASE, bus.OCUPADO, bus.FIN, bus.ERROR_CMD, bus.PAUSA, bus.VALVULA_AGUA,
            bus.MOTOR_LAVADO, bus.MOTOR_CENTRIF, bus.CALENTADOR};
  endfunction

  task automatic apply_stimulus(logic sec, logic lav, logic pes, logic door);
    bus.SECADO         = sec;
    bus.LAVADO         = lav;
    bus.LAVADO_PESADO  = pes;
    bus.PUERTA_ABIERTA = door;
  endtask

  task automatic push(int c0, int len, logic [10:0] v, string tag);
    for (int i = 0; i < len; i++) begin
      exp_t e;
      e.cyc = c0 + i;
      e.v   = v;
      e.tag = tag;
      sb.push_back(e);
    end
  endtask

  task automatic check_output();
    exp_t        e;
    logic [10:0] obs;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      obs = observed();
      vectors++;
      assert ((e.cyc == cyc) && (obs === e.v)) else begin
        miscompares++;
        $error("[TB] FAIL %s cyc %0d (due %0d): observed %b expected %b", e.tag, cyc, e.cyc, obs, e.v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_output();
  endtask

  task automatic run_until(int c);
    while (cyc < c) tick();
  endtask

  task automatic idle_ticks(int k);
    int t;
    t = cyc + k;
    push(cyc + 1, k, v_idle, "idle");
    run_until(t);
  endtask

  initial begin
    int n;
    v_idle  = vec(3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    v_llen  = vec(3'd1, 1, 0, 0, 0, 1, 0, 0, 0);
    v_lav   = vec(3'd2, 1, 0, 0, 0, 0, 1, 0, 0);
    v_lavp  = vec(3'd2, 1, 0, 0, 0, 0, 1, 0, 1);
    v_enj   = vec(3'd3, 1, 0, 0, 0, 1, 1, 0, 0);
    v_cen   = vec(3'd4, 1, 0, 0, 0, 0, 0, 1, 0);
    v_sec   = vec(3'd5, 1, 0, 0, 0, 0, 1, 0, 1);
    v_fin   = vec(3'd6, 0, 1, 0, 0, 0, 0, 0, 0);
    v_err   = vec(3'd0, 0, 0, 1, 0, 0, 0, 0, 0);
    v_pausa = vec(3'd2, 1, 0, 0, 1, 0, 0, 0, 0);
    cyc = 0;
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    apply_stimulus(0, 0, 0, 0);

    tick();
    push(cyc + 1, 2, v_idle, "reset");
    run_until(cyc + 2);
    reset = 1'b0;
    idle_ticks(3);

    // Normal wash; a dry edge mid-run must be dropped without an error pulse.
    n = cyc;
    apply_stimulus(0, 1, 0, 0);
    push(n + 1, 8, v_llen, "wash_llenado");
    push(n + 9, 16, v_lav, "wash_lavado");
    push(n + 25, 8, v_enj, "wash_enjuague");
    push(n + 33, 8, v_cen, "wash_centrif");
    push(n + 41, 1, v_fin, "wash_fin");
    push(n + 42, 2, v_idle, "wash_idle");
    run_until(n + 20);
    apply_stimulus(1, 1, 0, 0);
    run_until(n + 22);
    apply_stimulus(0, 1, 0, 0);
    run_until(n + 43);
    apply_stimulus(0, 0, 0, 0);
    idle_ticks(2);

    n = cyc;
    apply_stimulus(0, 0, 1, 0);
    push(n + 1, 8, v_llen, "heavy_llenado");
    push(n + 9, 32, v_lavp, "heavy_lavado");
    push(n + 41, 8, v_enj, "heavy_enjuague");
    push(n + 49, 8, v_cen, "heavy_centrif");
    push(n + 57, 1, v_fin, "heavy_fin");
    push(n + 58, 1, v_idle, "heavy_idle");
    run_until(n + 58);
    apply_stimulus(0, 0, 0, 0);
    idle_ticks(2);

    n = cyc;
    apply_stimulus(1, 1, 0, 0);
    push(n + 1, 1, v_err, "dual_edge_err");
    push(n + 2, 2, v_idle, "dual_edge_idle");
    run_until(n + 3);
    apply_stimulus(0, 0, 0, 0);
    idle_ticks(1);

    n = cyc;
    apply_stimulus(1, 0, 0, 1);
    push(n + 1, 1, v_err, "door_edge_err");
    push(n + 2, 2, v_idle, "door_edge_idle");
    run_until(n + 3);
    apply_stimulus(0, 0, 0, 0);
    idle_ticks(2);

    // Door open for 5 cycles during the wash phase stretches it by exactly 5.
    n = cyc;
    apply_stimulus(0, 1, 0, 0);
    push(n + 1, 8, v_llen, "door_llenado");
    push(n + 9, 4, v_lav, "door_lavado_a");
    push(n + 13, 5, v_pausa, "door_pausa");
    push(n + 18, 12, v_lav, "door_lavado_b");
    push(n + 30, 8, v_enj, "door_enjuague");
    push(n + 38, 8, v_cen, "door_centrif");
    push(n + 46, 1, v_fin, "door_fin");
    push(n + 47, 1, v_idle, "door_idle");
    run_until(n + 12);
    apply_stimulus(0, 1, 0, 1);
    run_until(n + 17);
    apply_stimulus(0, 1, 0, 0);
    run_until(n + 47);

    reset = 1'b1;
    apply_stimulus(1, 1, 1, 0);
    push(cyc + 1, 2, v_idle, "rst_hold");
    run_until(cyc + 2);
    reset = 1'b0;
    idle_ticks(5);
    apply_stimulus(0, 0, 0, 0);
    idle_ticks(2);

    n = cyc;
    apply_stimulus(1, 0, 0, 0);
    push(n + 1, 16, v_sec, "dry_secado");
    push(n + 17, 1, v_fin, "dry_fin");
    push(n + 18, 1, v_idle, "dry_idle");
    run_until(n + 18);
    apply_stimulus(0, 0, 0, 0);
    idle_ticks(2);

    // Reset in the spin phase aborts immediately and no completion pulse follows.
    n = cyc;
    apply_stimulus(0, 1, 0, 0);
    push(n + 1, 8, v_llen, "abort_llenado");
    push(n + 9, 16, v_lav, "abort_lavado");
    push(n + 25, 8, v_enj, "abort_enjuague");
    push(n + 33, 3, v_cen, "abort_centrif");
    run_until(n + 35);
    reset = 1'b1;
    push(n + 36, 1, v_idle, "abort_reset");
    run_until(n + 36);
    reset = 1'b0;
    push(n + 37, 24, v_idle, "abort_no_fin");
    run_until(n + 60);

    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("[TB] FAIL drain: observed %0d pending expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
